// File: rtl/cpu_bus_capture.sv
// CPU bus front end: synchronises the async FC CPU bus into osc50, emits one write
// strobe per qualified M2 high phase, and runs an M2 activity watchdog.
module cpu_bus_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int M2_MIN_HIGH = 4,
  parameter int WDOG_CYCLES = 200,
  parameter int ALIVE_EDGES = 2
) (
  input  logic        osc50,
  input  logic        m2_rst,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data,
  output logic        wr_valid,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_is_rom,
  output logic        m2_alive,
  output logic        console_rst_n
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam int EC_W = $clog2(ALIVE_EDGES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);
  localparam logic [EC_W-1:0] EC_MAX = EC_W'(ALIVE_EDGES);
  localparam logic [7:0]      MIN_HI = 8'(M2_MIN_HIGH);

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        is_rom;
    logic        is_wr;
  } shadow_t;

  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_EMIT} cap_t;
  typedef enum logic [1:0] {W_DEAD, W_ARMING, W_ALIVE} wd_t;

  // Control lines get a synchroniser; addr/data get an equal-depth delay so sample k lines up.
  logic [SYNC_STAGES-1:0]       m2_sync, romsel_sync, rw_sync;
  logic [SYNC_STAGES-1:0][14:0] addr_dly;
  logic [SYNC_STAGES-1:0][7:0]  data_dly;
  logic                         m2_q;

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      m2_sync     <= '0;
      romsel_sync <= '0;
      rw_sync     <= '0;
      addr_dly    <= '0;
      data_dly    <= '0;
      m2_q        <= 1'b0;
    end else begin
      m2_sync[0]     <= m2;
      romsel_sync[0] <= romsel;
      rw_sync[0]     <= cpu_rw_in;
      addr_dly[0]    <= cpu_addr_in;
      data_dly[0]    <= cpu_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        m2_sync[i]     <= m2_sync[i-1];
        romsel_sync[i] <= romsel_sync[i-1];
        rw_sync[i]     <= rw_sync[i-1];
        addr_dly[i]    <= addr_dly[i-1];
        data_dly[i]    <= data_dly[i-1];
      end
      m2_q <= m2_sync[SYNC_STAGES-1];
    end
  end

  logic m2_s, m2_rise, m2_edge;
  assign m2_s    = m2_sync[SYNC_STAGES-1];
  assign m2_rise = m2_s & ~m2_q;
  assign m2_edge = m2_s ^ m2_q;

  // ---------------- write capture ----------------
  cap_t    cap_state, cap_next;
  shadow_t shadow;
  logic [7:0] hi_cnt;

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) cap_state <= C_IDLE;
    else         cap_state <= cap_next;
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      C_IDLE:  if (m2_rise) cap_next = C_HIGH;
      C_HIGH:  if (!m2_s) cap_next = (hi_cnt >= MIN_HI && shadow.is_wr) ? C_EMIT : C_IDLE;
      C_EMIT:  cap_next = m2_s ? C_HIGH : C_IDLE;
      default: cap_next = C_IDLE;
    endcase
  end

  always_comb begin
    wr_valid = (cap_state == C_EMIT);
  end

  // Shadow tracks every high-phase sample, so the last one before M2 falls wins.
  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      hi_cnt    <= '0;
      shadow    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_is_rom <= 1'b0;
    end else begin
      if (cap_state != C_HIGH && cap_next == C_HIGH)
        hi_cnt <= 8'd1;
      else if (cap_state == C_HIGH && m2_s && hi_cnt != 8'hFF)
        hi_cnt <= hi_cnt + 8'd1;
      if (m2_s && (cap_state == C_HIGH || cap_next == C_HIGH))
        shadow <= '{addr: addr_dly[SYNC_STAGES-1], data: data_dly[SYNC_STAGES-1],
                    is_rom: ~romsel_sync[SYNC_STAGES-1], is_wr: ~rw_sync[SYNC_STAGES-1]};
      if (cap_state == C_HIGH && cap_next == C_EMIT) begin
        wr_addr   <= shadow.addr;
        wr_data   <= shadow.data;
        wr_is_rom <= shadow.is_rom;
      end
    end
  end

  // ---------------- M2 watchdog ----------------
  wd_t             wd_state, wd_next;
  logic [WD_W-1:0] wdog;
  logic [EC_W-1:0] edge_cnt;
  logic            wd_expired;

  assign wd_expired = (wdog == WD_MAX);

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) wd_state <= W_DEAD;
    else         wd_state <= wd_next;
  end

  always_comb begin
    wd_next = wd_state;
    case (wd_state)
      W_DEAD:   if (m2_rise) wd_next = W_ARMING;
      W_ARMING: if (edge_cnt == EC_MAX) wd_next = W_ALIVE;
                else if (wd_expired)    wd_next = W_DEAD;
      W_ALIVE:  if (wd_expired) wd_next = W_DEAD;
      default:  wd_next = W_DEAD;
    endcase
  end

  always_comb begin
    m2_alive      = (wd_state == W_ALIVE);
    console_rst_n = (wd_state == W_ALIVE);
  end

  always_ff @(posedge osc50 or negedge m2_rst) begin
    if (!m2_rst) begin
      wdog     <= '0;
      edge_cnt <= '0;
    end else begin
      if (m2_edge)          wdog <= '0;
      else if (!wd_expired) wdog <= wdog + 1'b1;
      if (wd_state == W_DEAD && m2_rise)
        edge_cnt <= EC_W'(1);
      else if (wd_state == W_ARMING && m2_rise && edge_cnt != EC_MAX)
        edge_cnt <= edge_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_bus_capture.sv
// Directed bench for cpu_bus_capture: timestamp-based model checked every cycle plus
// hand-computed expectations for latency, captured values and watchdog timing.
module tb_cpu_bus_capture;
  localparam int S = 2, MINH = 4, WD = 200, AE = 2;

  logic        osc50 = 1'b0, m2_rst = 1'b0, m2 = 1'b0, romsel = 1'b1, cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data = '0;
  logic        wr_valid, wr_is_rom, m2_alive, console_rst_n;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;

  int n_chk = 0, n_fail = 0, strobes = 0;

  cpu_bus_capture #(.SYNC_STAGES(S), .M2_MIN_HIGH(MINH), .WDOG_CYCLES(WD), .ALIVE_EDGES(AE)) dut (
    .osc50(osc50), .m2_rst(m2_rst), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data(cpu_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_is_rom(wr_is_rom), .m2_alive(m2_alive), .console_rst_n(console_rst_n));

  initial forever #10 osc50 = ~osc50;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic m2, romsel, rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } pin_t;

  pin_t        dq[$];
  pin_t        s0, s1, s2;         // synced bus view in the current and two previous cycles
  int          run0, run1, run2;   // length of the synced-high run ending at s0/s1/s2
  int          n, last_e, mst, ecnt;
  logic        e_valid, e_rom, e_alive;
  logic [14:0] e_addr;
  logic [7:0]  e_data;

  initial forever begin
    @(posedge osc50);
    if (!m2_rst) begin
      dq = {}; s0 = '0; s1 = '0; s2 = '0; run0 = 0; run1 = 0; run2 = 0;
      n = 0; last_e = -100000; mst = 0; ecnt = 0;
      e_valid = 0; e_rom = 0; e_alive = 0; e_addr = '0; e_data = '0;
    end else begin
      dq.push_back('{m2: m2, romsel: romsel, rw: cpu_rw_in, addr: cpu_addr_in, data: cpu_data});
      if (dq.size() > S) void'(dq.pop_front());
      s2 = s1; run2 = run1; s1 = s0; run1 = run0;
      s0 = (dq.size() == S) ? dq[0] : '0;
      run0 = s0.m2 ? run1 + 1 : 0;
      // strobe follows the cycle in which the synced fall is seen
      e_valid = s2.m2 && !s1.m2 && run2 >= MINH && !s2.rw;
      if (e_valid) begin
        e_addr = s2.addr; e_data = s2.data; e_rom = !s2.romsel;
      end
      // watchdog: 0 dead, 1 arming, 2 alive; decisions use the previous cycle's view
      begin
        bit rise1, dead1;
        rise1 = s1.m2 && !s2.m2;
        dead1 = (n - 2 - last_e) >= WD;
        case (mst)
          0: if (rise1) begin mst = 1; ecnt = 1; end
          1: if (ecnt == AE) mst = 2;
             else if (dead1) mst = 0;
             else if (rise1) ecnt++;
          default: if (dead1) mst = 0;
        endcase
        if (s1.m2 != s2.m2) last_e = n - 1;
      end
      e_alive = (mst == 2);
      n++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge osc50);
    if (wr_valid === 1'b1) strobes++;
    if (!m2_rst) begin
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_is_rom", wr_is_rom, 0);
      chk("rst_m2_alive", m2_alive, 0);
      chk("rst_console_rst_n", console_rst_n, 0);
    end else begin
      chk("wr_valid", wr_valid, e_valid);
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
      chk("wr_is_rom", wr_is_rom, e_rom);
      chk("m2_alive", m2_alive, e_alive);
      chk("console_rst_n", console_rst_n, e_alive);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge osc50); #1;
  endtask

  task automatic pulse(input int hi, input int lo, input logic rw, input logic rs,
                       input logic [14:0] a, input logic [7:0] d,
                       output int nstrb, output int lat,
                       output logic [14:0] ga, output logic [7:0] gd, output logic grom);
    cpu_addr_in = a; cpu_data = d; cpu_rw_in = rw; romsel = rs; m2 = 1'b1;
    repeat (hi) step();
    m2 = 1'b0; nstrb = 0; lat = -1; ga = '0; gd = '0; grom = 1'b0;
    for (int i = 1; i <= lo; i++) begin
      step();
      if (wr_valid === 1'b1) begin
        nstrb++;
        if (lat < 0) begin lat = i; ga = wr_addr; gd = wr_data; grom = wr_is_rom; end
      end
    end
    cpu_rw_in = 1'b1; romsel = 1'b1;
  endtask

  initial begin
    int ns, lt, base;
    logic [14:0] ga;
    logic [7:0]  gd;
    logic        gr;

    repeat (3) step();
    chk("reset_alive", m2_alive, 0);
    chk("reset_wr_valid", wr_valid, 0);
    m2_rst = 1'b1;

    base = strobes;
    repeat (300) step();
    chk("idle_alive", m2_alive, 0);
    chk("idle_console_rst_n", console_rst_n, 0);
    chk("idle_strobes", strobes - base, 0);

    // ROM write
    pulse(14, 12, 1'b0, 1'b0, 15'h7FFF, 8'h15, ns, lt, ga, gd, gr);
    chk("wr_count", ns, 1);
    chk("wr_latency", lt, S + 1);
    chk("wr_addr_val", ga, 15'h7FFF);
    chk("wr_data_val", gd, 8'h15);
    chk("wr_rom_val", gr, 1);

    // read: no strobe, previous capture held
    pulse(14, 12, 1'b1, 1'b0, 15'h1234, 8'hAA, ns, lt, ga, gd, gr);
    chk("rd_count", ns, 0);
    chk("rd_hold_addr", wr_addr, 15'h7FFF);
    chk("rd_hold_data", wr_data, 8'h15);

    // glitch, then a normal non-ROM write
    pulse(2, 12, 1'b0, 1'b0, 15'h0AAA, 8'h5A, ns, lt, ga, gd, gr);
    chk("glitch_count", ns, 0);
    pulse(14, 12, 1'b0, 1'b1, 15'h0123, 8'hC3, ns, lt, ga, gd, gr);
    chk("post_glitch_count", ns, 1);
    chk("post_glitch_addr", ga, 15'h0123);
    chk("post_glitch_data", gd, 8'hC3);
    chk("post_glitch_rom", gr, 0);

    // high-time boundary: one below and exactly at the minimum
    pulse(MINH - 1, 12, 1'b0, 1'b0, 15'h1111, 8'h11, ns, lt, ga, gd, gr);
    chk("min_minus1_count", ns, 0);
    pulse(MINH, 12, 1'b0, 1'b0, 15'h2468, 8'h81, ns, lt, ga, gd, gr);
    chk("min_count", ns, 1);
    chk("min_latency", lt, S + 1);
    chk("min_addr", ga, 15'h2468);

    // back-to-back: next M2 rise lands in the EMIT cycle
    base = strobes;
    pulse(6, 1, 1'b0, 1'b0, 15'h0F00, 8'h01, ns, lt, ga, gd, gr);
    pulse(6, 12, 1'b0, 1'b1, 15'h00F0, 8'h02, ns, lt, ga, gd, gr);
    chk("b2b_total", strobes - base, 2);
    chk("b2b_addr", wr_addr, 15'h00F0);
    chk("b2b_rom", wr_is_rom, 0);

    // watchdog
    for (int k = 0; k < 10; k++) pulse(14, 12, 1'b1, 1'b1, 15'h0, 8'h0, ns, lt, ga, gd, gr);
    chk("wd_alive_running", m2_alive, 1);
    for (int i = 1; i <= 250; i++) begin
      step();
      if (i == 191) chk("wd_alive_before", m2_alive, 1);
      if (i == 192) begin
        chk("wd_dead_alive", m2_alive, 0);
        chk("wd_dead_rstn", console_rst_n, 0);
      end
    end
    pulse(14, 12, 1'b1, 1'b1, 15'h0, 8'h0, ns, lt, ga, gd, gr);
    chk("wd_arming_one_edge", m2_alive, 0);
    pulse(14, 12, 1'b1, 1'b1, 15'h0, 8'h0, ns, lt, ga, gd, gr);
    chk("wd_release_alive", m2_alive, 1);
    chk("wd_release_rstn", console_rst_n, 1);

    // reset while a write is in its high phase
    base = strobes;
    cpu_addr_in = 15'h3333; cpu_data = 8'h77; cpu_rw_in = 1'b0; romsel = 1'b0; m2 = 1'b1;
    repeat (6) step();
    m2_rst = 1'b0;
    step();
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_alive", m2_alive, 0);
    m2 = 1'b0;
    repeat (3) step();
    m2_rst = 1'b1;
    repeat (10) step();
    chk("midrst_strobes", strobes - base, 0);
    pulse(14, 12, 1'b0, 1'b0, 15'h0F0F, 8'h3C, ns, lt, ga, gd, gr);
    chk("recover_count", ns, 1);
    chk("recover_addr", ga, 15'h0F0F);
    chk("recover_data", gd, 8'h3C);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
